id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register with ALU-control decode and operand forwarding; directly feeds the alu (A, B, ALUControl).
//  Accepts one decoded instruction per cycle from decode via valid/ready, registers it, and presents forwarded operands to EX.
//  Supports stall (out_ready low) and flush (branch taken / redirect).
// PARAMETERS
//  XLEN      32   datapath width of operands and results
//  REG_AW    5    register-index width
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high
//  in_valid   in   1       decode presents an instruction
//  in_ready   out  1       stage can accept this cycle
//  RD1D       in   XLEN    rs1 register-file read data
//  RD2D       in   XLEN    rs2 register-file read data
//  ImmExtD    in   XLEN    sign-extended immediate
//  Rs1D/Rs2D/RdD in REG_AW source/dest indices
//  ALUOpD     in   2       00 mem-addr, 01 branch, 10 R/I-type, 11 reserved
//  funct3D    in   3       instruction funct3
//  funct7b5D  in   1       instruction bit 30
//  op5D       in   1       opcode bit 5 (1 = R-type)
//  ALUSrcD    in   1       1: SrcB = immediate
//  RegWriteD  in   1       instruction writes rd
//  flush      in   1       kill stage contents
//  RdM/RegWriteM/ALUResultM in REG_AW/1/XLEN  EX/MEM forwarding source
//  RdW/RegWriteW/ResultW    in REG_AW/1/XLEN  MEM/WB forwarding source
//  out_valid  out  1       EX holds a valid instruction
//  out_ready  in   1       downstream consumes this cycle
//  SrcAE      out  XLEN    alu A
//  SrcBE      out  XLEN    alu B
//  ALUControlE out 4       alu opcode
//  WriteDataE out  XLEN    forwarded rs2 (store data)
//  RdE/RegWriteE out REG_AW/1  destination info to EX/MEM
// BEHAVIOUR
//  - Reset: out_valid=0, all stage registers 0 -> SrcAE=SrcBE=WriteDataE=0, ALUControlE=0000, RdE=0, RegWriteE=0.
//  - in_ready = !out_valid | out_ready (combinational); transfer when in_valid & in_ready; latency 1 cycle.
//  - Hold: out_valid & !out_ready -> all registers unchanged; outputs stable until consumed.
//  - flush: next cycle out_valid=0, RegWriteE=0; priority over accept and hold. flush and reset same cycle -> reset.
//  - Consume without new input: out_valid clears.
//  - Decode on D side (registered into ALUControlE): ALUOp 00->ADD; 01->SUB; 11->ADD;
//    10 by funct3: 000 SUB if (funct7b5&op5) else ADD; 001 SLL; 010 SLT; 100 XOR; 101 SRL; 110 OR; 111 AND; 011 ADD.
//  - Forwarding (combinational on registered Rs1E/Rs2E): M match = RegWriteM & RdM!=0 & RdM==RsE -> ALUResultM;
//    else W match -> ResultW; else registered RD. M wins over W. Index 0 never forwarded.
//  - SrcAE = fwd rs1; WriteDataE = fwd rs2; SrcBE = ALUSrcE ? ImmExtE : fwd rs2.
//  - Forward sources are live each cycle, so held outputs may change if M/W change during a stall; a forward
//    source that retires mid-stall is lost (the hazard unit must not stall across a retirement).
// STRUCTURE
//  - Package x_risc_pkg: typedef enum logic[3:0] alu_ctrl_t {ADD=0000,SUB=0001,AND=0010,OR=0011,XOR=0100,SLT=0111,
//    SLL=1000,SRL=1001}; typedef alu_op_t (2 bits); XLEN/REG_AW constants.
//  - Sub-module alu_decoder (pure combinational ALUOp/funct3/funct7b5/op5 -> alu_ctrl_t); forwarding mux inline.
// TESTING
//  1 Reset 3 cycles -> out_valid=0, SrcAE=SrcBE=0, ALUControlE=0000, in_ready=1.
//  2 R-type sub: ALUOpD=10, funct3=000, funct7b5=1, op5=1, RD1D=8, RD2D=3 -> next cycle SrcAE=8, SrcBE=3, ALUControlE=0001.
//  3 Forward: Rs1E=5, RdM=5, RegWriteM=1, ALUResultM=42, RdW=5, ResultW=7 -> SrcAE=42; drop RegWriteM -> SrcAE=7; RdM=0 -> no fwd.
//  4 Stall: out_valid=1, out_ready=0 for 4 cycles, in_valid=1 -> in_ready=0, ALUControlE/RdE stable; out_ready=1 -> next instr loads.
//  5 Flush while in_valid=1, in_ready=1 -> next cycle out_valid=0, RegWriteE=0; following accept resumes normally.
//  6 I-type: ALUSrcD=1, ImmExtD=-4, funct3=101, ALUOp=10 -> SrcBE=32'hFFFF_FFFC, ALUControlE=1001; funct3=010 -> 0111.

Source files
------------

// File: rtl/x_risc_pkg.sv
// Shared types and width constants for the integer pipeline.
// ALU opcodes and decode-side ALUOp classes live here so every stage agrees on the encoding.
package x_risc_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [3:0] {
    ADD = 4'b0000,
    SUB = 4'b0001,
    AND = 4'b0010,
    OR  = 4'b0011,
    XOR = 4'b0100,
    SLT = 4'b0111,
    SLL = 4'b1000,
    SRL = 4'b1001
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RI     = 2'b10,
    ALUOP_RSVD   = 2'b11
  } alu_op_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-EX bundle: decoded instruction with valid/ready in, registered EX operands with valid/ready out.
// master = decode/EX surroundings, slave = the ID/EX stage itself.
interface id_ex_stage_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
);

  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   RD1D;
  logic [XLEN-1:0]   RD2D;
  logic [XLEN-1:0]   ImmExtD;
  logic [REG_AW-1:0] Rs1D;
  logic [REG_AW-1:0] Rs2D;
  logic [REG_AW-1:0] RdD;
  logic [1:0]        ALUOpD;
  logic [2:0]        funct3D;
  logic              funct7b5D;
  logic              op5D;
  logic              ALUSrcD;
  logic              RegWriteD;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   SrcAE;
  logic [XLEN-1:0]   SrcBE;
  logic [3:0]        ALUControlE;
  logic [XLEN-1:0]   WriteDataE;
  logic [REG_AW-1:0] RdE;
  logic              RegWriteE;

  modport master (
    output in_valid, RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD,
           ALUOpD, funct3D, funct7b5D, op5D, ALUSrcD, RegWriteD,
    input  in_ready,
    input  out_valid, SrcAE, SrcBE, ALUControlE, WriteDataE, RdE, RegWriteE,
    output out_ready
  );

  modport slave (
    input  in_valid, RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD,
           ALUOpD, funct3D, funct7b5D, op5D, ALUSrcD, RegWriteD,
    output in_ready,
    output out_valid, SrcAE, SrcBE, ALUControlE, WriteDataE, RdE, RegWriteE,
    input  out_ready
  );

endinterface

// File: rtl/id_ex_stage_alu_decoder.sv
// Pure combinational ALU-control decode from ALUOp/funct3/funct7b5/op5.
// Subtract only for R-type funct3=000 with bit 30 set; I-type ADDI never subtracts.
module alu_decoder
  import x_risc_pkg::*;
(
  input  alu_op_t    ALUOp,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output alu_ctrl_t  ALUControl
);

  always_comb begin
    ALUControl = ADD;
    unique case (ALUOp)
      ALUOP_MEM:    ALUControl = ADD;
      ALUOP_BRANCH: ALUControl = SUB;
      ALUOP_RSVD:   ALUControl = ADD;
      ALUOP_RI: begin
        case (funct3)
          3'b000:  ALUControl = (funct7b5 && op5) ? SUB : ADD;
          3'b001:  ALUControl = SLL;
          3'b010:  ALUControl = SLT;
          3'b011:  ALUControl = ADD;
          3'b100:  ALUControl = XOR;
          3'b101:  ALUControl = SRL;
          3'b110:  ALUControl = OR;
          3'b111:  ALUControl = AND;
          default: ALUControl = ADD;
        endcase
      end
      default: ALUControl = ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes ALU control on the D side, registers the instruction,
// and presents EX/MEM- and MEM/WB-forwarded operands to the ALU.
module id_ex_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  id_ex_stage_if.slave      bus,
  input  logic              flush,
  input  logic [REG_AW-1:0] RdM,
  input  logic              RegWriteM,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteW,
  input  logic [XLEN-1:0]   ResultW
);

  import x_risc_pkg::*;

  alu_ctrl_t         ctrl_d;
  alu_ctrl_t         ctrl_q;
  logic              valid_q;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic [REG_AW-1:0] rd_q;
  logic              regwrite_q;
  logic              alusrc_q;
  logic [XLEN-1:0]   rd1_q;
  logic [XLEN-1:0]   rd2_q;
  logic [XLEN-1:0]   imm_q;
  logic              ready_c;
  logic              accept;
  logic [XLEN-1:0]   fwd_a;
  logic [XLEN-1:0]   fwd_b;

  alu_decoder u_alu_decoder (
    .ALUOp      (alu_op_t'(bus.ALUOpD)),
    .funct3     (bus.funct3D),
    .funct7b5   (bus.funct7b5D),
    .op5        (bus.op5D),
    .ALUControl (ctrl_d)
  );

  always_comb begin
    ready_c = !valid_q || bus.out_ready;
    accept  = bus.in_valid && ready_c;
  end

  // Flush only needs to kill valid and the write-enable; the stale payload is harmless.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      ctrl_q     <= ADD;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      alusrc_q   <= 1'b0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
    end else if (flush) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
    end else if (accept) begin
      valid_q    <= 1'b1;
      ctrl_q     <= ctrl_d;
      rs1_q      <= bus.Rs1D;
      rs2_q      <= bus.Rs2D;
      rd_q       <= bus.RdD;
      regwrite_q <= bus.RegWriteD;
      alusrc_q   <= bus.ALUSrcD;
      rd1_q      <= bus.RD1D;
      rd2_q      <= bus.RD2D;
      imm_q      <= bus.ImmExtD;
    end else if (bus.out_ready) begin
      valid_q    <= 1'b0;
    end
  end

  // Forward sources are sampled live; the nearer (EX/MEM) producer wins, x0 is never forwarded.
  always_comb begin
    if (RegWriteM && (RdM != '0) && (RdM == rs1_q))
      fwd_a = ALUResultM;
    else if (RegWriteW && (RdW != '0) && (RdW == rs1_q))
      fwd_a = ResultW;
    else
      fwd_a = rd1_q;

    if (RegWriteM && (RdM != '0) && (RdM == rs2_q))
      fwd_b = ALUResultM;
    else if (RegWriteW && (RdW != '0) && (RdW == rs2_q))
      fwd_b = ResultW;
    else
      fwd_b = rd2_q;
  end

  always_comb begin
    bus.in_ready    = ready_c;
    bus.out_valid   = valid_q;
    bus.SrcAE       = fwd_a;
    bus.SrcBE       = alusrc_q ? imm_q : fwd_b;
    bus.WriteDataE  = fwd_b;
    bus.ALUControlE = ctrl_q;
    bus.RdE         = rd_q;
    bus.RegWriteE   = regwrite_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus a randomized phase, with a scoreboard
// that tracks the instruction held in EX and re-derives forwarded operands each cycle.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [4:0]  RdM;
  logic        RegWriteM;
  logic [31:0] ALUResultM;
  logic [4:0]  RdW;
  logic        RegWriteW;
  logic [31:0] ResultW;

  int checks   = 0;
  int failures = 0;
  int ncons    = 0;

  typedef struct {
    logic [3:0]  ctrl;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        alusrc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
  } exp_t;

  exp_t sb[$];

  id_ex_stage_if #(.XLEN(32), .REG_AW(5)) ifc ();

  id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (ifc),
    .flush      (flush),
    .RdM        (RdM),
    .RegWriteM  (RegWriteM),
    .ALUResultM (ALUResultM),
    .RdW        (RdW),
    .RegWriteW  (RegWriteW),
    .ResultW    (ResultW)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_ctrl(input logic [1:0] op, input logic [2:0] f3,
                                            input logic f7, input logic o5);
    if (op == 2'b01) return 4'b0001;
    if (op != 2'b10) return 4'b0000;
    case (f3)
      3'b000:  return (f7 && o5) ? 4'b0001 : 4'b0000;
      3'b001:  return 4'b1000;
      3'b010:  return 4'b0111;
      3'b100:  return 4'b0100;
      3'b101:  return 4'b1001;
      3'b110:  return 4'b0011;
      3'b111:  return 4'b0010;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] model_fwd(input logic [4:0] rs, input logic [31:0] rf);
    if (rs != 5'd0 && RegWriteM && RdM == rs) return ALUResultM;
    if (rs != 5'd0 && RegWriteW && RdW == rs) return ResultW;
    return rf;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t        e;
    exp_t        n;
    logic [31:0] b;
    logic        rdy;
    rdy = (sb.size() == 0) || ifc.out_ready;
    check("out_valid", {31'd0, ifc.out_valid}, {31'd0, sb.size() != 0});
    check("in_ready", {31'd0, ifc.in_ready}, {31'd0, rdy});
    if (sb.size() != 0) begin
      e = sb[0];
      b = model_fwd(e.rs2, e.rd2);
      check("sb_ctrl", {28'd0, ifc.ALUControlE}, {28'd0, e.ctrl});
      check("sb_rd", {27'd0, ifc.RdE}, {27'd0, e.rd});
      check("sb_regwrite", {31'd0, ifc.RegWriteE}, {31'd0, e.rw});
      check("sb_srca", ifc.SrcAE, model_fwd(e.rs1, e.rd1));
      check("sb_wdata", ifc.WriteDataE, b);
      check("sb_srcb", ifc.SrcBE, e.alusrc ? e.imm : b);
      if (ifc.out_ready) begin
        void'(sb.pop_front());
        ncons++;
      end
    end
    if (reset || flush) begin
      sb.delete();
    end else if (ifc.in_valid && rdy) begin
      n.ctrl   = model_ctrl(ifc.ALUOpD, ifc.funct3D, ifc.funct7b5D, ifc.op5D);
      n.rs1    = ifc.Rs1D;
      n.rs2    = ifc.Rs2D;
      n.rd     = ifc.RdD;
      n.rw     = ifc.RegWriteD;
      n.alusrc = ifc.ALUSrcD;
      n.rd1    = ifc.RD1D;
      n.rd2    = ifc.RD2D;
      n.imm    = ifc.ImmExtD;
      sb.push_back(n);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [1:0] op, input logic [2:0] f3, input logic f7, input logic o5,
                       input logic src, input logic rw,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im);
    ifc.in_valid  = 1'b1;
    ifc.Rs1D      = rs1;
    ifc.Rs2D      = rs2;
    ifc.RdD       = rd;
    ifc.ALUOpD    = op;
    ifc.funct3D   = f3;
    ifc.funct7b5D = f7;
    ifc.op5D      = o5;
    ifc.ALUSrcD   = src;
    ifc.RegWriteD = rw;
    ifc.RD1D      = d1;
    ifc.RD2D      = d2;
    ifc.ImmExtD   = im;
  endtask

  task automatic clear_fwd();
    RdM = '0; RegWriteM = 1'b0; ALUResultM = '0;
    RdW = '0; RegWriteW = 1'b0; ResultW = '0;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    clear_fwd();
    drive(5'd0, 5'd0, 5'd0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;

    // Reset
    repeat (3) step();
    check("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    check("rst_srca", ifc.SrcAE, 32'd0);
    check("rst_srcb", ifc.SrcBE, 32'd0);
    check("rst_wdata", ifc.WriteDataE, 32'd0);
    check("rst_ctrl", {28'd0, ifc.ALUControlE}, 32'd0);
    check("rst_rd", {27'd0, ifc.RdE}, 32'd0);
    check("rst_regwrite", {31'd0, ifc.RegWriteE}, 32'd0);
    check("rst_in_ready", {31'd0, ifc.in_ready}, 32'd1);
    reset = 1'b0;

    // R-type SUB, one-cycle latency
    ifc.out_ready = 1'b1;
    drive(5'd1, 5'd2, 5'd3, 2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 32'd8, 32'd3, 32'd0);
    step();
    ifc.in_valid = 1'b0;
    #1;
    check("sub_out_valid", {31'd0, ifc.out_valid}, 32'd1);
    check("sub_srca", ifc.SrcAE, 32'd8);
    check("sub_srcb", ifc.SrcBE, 32'd3);
    check("sub_ctrl", {28'd0, ifc.ALUControlE}, 32'd1);
    step();
    check("consume_clears", {31'd0, ifc.out_valid}, 32'd0);

    // Forwarding priority and x0 exclusion while held
    ifc.out_ready = 1'b0;
    drive(5'd5, 5'd6, 5'd7, 2'b10, 3'b110, 1'b0, 1'b1, 1'b0, 1'b1, 32'd100, 32'd200, 32'd0);
    step();
    ifc.in_valid = 1'b0;
    RdM = 5'd5; RegWriteM = 1'b1; ALUResultM = 32'd42;
    RdW = 5'd5; RegWriteW = 1'b1; ResultW = 32'd7;
    #1 check("fwd_m_wins", ifc.SrcAE, 32'd42);
    RegWriteM = 1'b0;
    #1 check("fwd_w", ifc.SrcAE, 32'd7);
    RegWriteM = 1'b1; RdM = 5'd0;
    #1 check("fwd_rdm0", ifc.SrcAE, 32'd7);
    RegWriteW = 1'b0;
    #1 check("fwd_none", ifc.SrcAE, 32'd100);
    RdM = 5'd6; ALUResultM = 32'd11;
    RdW = 5'd6; RegWriteW = 1'b1; ResultW = 32'd12;
    #1 check("fwd_wdata", ifc.WriteDataE, 32'd11);
    check("fwd_srcb", ifc.SrcBE, 32'd11);
    step();
    step();
    ifc.out_ready = 1'b1;
    step();
    clear_fwd();

    ifc.out_ready = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 32'd55, 32'd66, 32'd0);
    RdM = 5'd0; RegWriteM = 1'b1; ALUResultM = 32'd99;
    RdW = 5'd0; RegWriteW = 1'b1; ResultW = 32'd98;
    step();
    ifc.in_valid = 1'b0;
    #1 check("x0_srca", ifc.SrcAE, 32'd55);
    check("x0_wdata", ifc.WriteDataE, 32'd66);
    clear_fwd();
    ifc.out_ready = 1'b1;
    step();

    // Stall with a pending instruction
    ifc.out_ready = 1'b0;
    drive(5'd1, 5'd2, 5'd9, 2'b10, 3'b111, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0F0F, 32'h00FF, 32'd0);
    step();
    drive(5'd3, 5'd4, 5'd10, 2'b10, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1234, 32'h4321, 32'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_in_ready", {31'd0, ifc.in_ready}, 32'd0);
      check("stall_ctrl", {28'd0, ifc.ALUControlE}, 32'd2);
      check("stall_rd", {27'd0, ifc.RdE}, 32'd9);
      step();
    end
    ifc.out_ready = 1'b1;
    #1 check("unstall_in_ready", {31'd0, ifc.in_ready}, 32'd1);
    step();
    ifc.in_valid = 1'b0;
    #1 check("next_ctrl", {28'd0, ifc.ALUControlE}, 32'd4);
    check("next_rd", {27'd0, ifc.RdE}, 32'd10);

    // Flush beats a same-cycle accept
    drive(5'd1, 5'd1, 5'd11, 2'b10, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1, 32'd1, 32'd2, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(5'd2, 5'd3, 5'd12, 2'b10, 3'b011, 1'b0, 1'b1, 1'b0, 1'b1, 32'd20, 32'd30, 32'd0);
    #1;
    check("flush_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    check("flush_regwrite", {31'd0, ifc.RegWriteE}, 32'd0);
    step();
    ifc.in_valid = 1'b0;
    #1;
    check("post_flush_valid", {31'd0, ifc.out_valid}, 32'd1);
    check("post_flush_rd", {27'd0, ifc.RdE}, 32'd12);
    check("post_flush_regwrite", {31'd0, ifc.RegWriteE}, 32'd1);
    step();

    // I-type immediate path
    drive(5'd1, 5'd2, 5'd4, 2'b10, 3'b101, 1'b0, 1'b0, 1'b1, 1'b1, 32'd64, 32'd5, 32'hFFFF_FFFC);
    step();
    drive(5'd1, 5'd2, 5'd4, 2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, 32'd64, 32'd5, 32'hFFFF_FFFC);
    #1;
    check("itype_srcb", ifc.SrcBE, 32'hFFFF_FFFC);
    check("itype_srl", {28'd0, ifc.ALUControlE}, 32'd9);
    step();
    ifc.in_valid = 1'b0;
    #1 check("itype_slt", {28'd0, ifc.ALUControlE}, 32'd7);
    step();

    // Reset wins over a simultaneous flush and clears the payload too
    ifc.out_ready = 1'b0;
    drive(5'd1, 5'd2, 5'd13, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'd77, 32'd88, 32'd0);
    step();
    ifc.in_valid = 1'b0;
    reset = 1'b1;
    flush = 1'b1;
    step();
    reset = 1'b0;
    flush = 1'b0;
    #1;
    check("rstflush_valid", {31'd0, ifc.out_valid}, 32'd0);
    check("rstflush_rd", {27'd0, ifc.RdE}, 32'd0);
    check("rstflush_ctrl", {28'd0, ifc.ALUControlE}, 32'd0);
    check("rstflush_srca", ifc.SrcAE, 32'd0);

    // Randomized traffic, small register indices so forwarding hits often
    for (int i = 0; i < 300; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom, $urandom, $urandom);
      ifc.in_valid  = ($urandom_range(0, 3) != 0);
      ifc.out_ready = ($urandom_range(0, 9) < 7);
      flush         = ($urandom_range(0, 15) == 0);
      RdM        = 5'($urandom_range(0, 3));
      RegWriteM  = 1'($urandom_range(0, 1));
      ALUResultM = $urandom;
      RdW        = 5'($urandom_range(0, 3));
      RegWriteW  = 1'($urandom_range(0, 1));
      ResultW    = $urandom;
      step();
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    flush         = 1'b0;
    step();
    step();
    check("sb_drained", sb.size(), 32'd0);
    check("consumed_enough", {31'd0, ncons >= 60}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
